sm_job_receiver: RTL and testbench

//  Receiving end of the stage-dispatch link: accepts {target SM, stage type, job ID} beats from the dispatcher.

---
 rtl/shader_dispatch_pkg.sv | 19 +
 rtl/sm_job_fifo.sv | 75 +++++++
 rtl/sm_job_receiver.sv | 92 +++++++++
 tb/tb_sm_job_receiver.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/shader_dispatch_pkg.sv
// Shared definitions for the stage-dispatch link (dispatcher and job receiver).
// Stage codes 4..7 are not defined here but are still carried through unchanged.
package shader_dispatch_pkg;

    localparam int STAGE_W  = 3;
    localparam int JOB_ID_W = 32;

    localparam logic [STAGE_W-1:0] STAGE_VERTEX  = 3'd0;
    localparam logic [STAGE_W-1:0] STAGE_FRAG    = 3'd1;
    localparam logic [STAGE_W-1:0] STAGE_COMPUTE = 3'd2;
    localparam logic [STAGE_W-1:0] STAGE_RAY     = 3'd3;

    // One dispatch beat as seen on the link (stage code in the upper bits).
    typedef struct packed {
        logic [STAGE_W-1:0]  stage;
        logic [JOB_ID_W-1:0] job_id;
    } job_beat_t;

endpackage

// File: rtl/sm_job_fifo.sv
// Per-SM job queue: first-word-fall-through FIFO with wrap-bit pointers.
// Optional macro SMJR_OCCUPANCY_EN adds a registered occupancy count port.
module sm_job_fifo
    import shader_dispatch_pkg::*;
#(
    parameter int WIDTH = STAGE_W + JOB_ID_W,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
`ifdef SMJR_OCCUPANCY_EN
    ,
    output logic [AW:0]      count
`endif
);

    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // Same index with differing wrap bit means every slot is occupied.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    // A full queue refuses the write even if the head leaves this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head reads as zero while empty so a freshly reset queue shows zeros.
    assign head_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    // Pointer advance on accepted push/pop; reset discards all contents.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    // Entry storage, no reset needed since validity lives in the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

`ifdef SMJR_OCCUPANCY_EN
    logic [AW:0] count_reg;

    // Occupancy tracks push/pop at the same edge; simultaneous ops cancel.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_reg <= '0;
        end else if (do_push && !do_pop) begin
            count_reg <= count_reg + PTR_ONE;
        end else if (do_pop && !do_push) begin
            count_reg <= count_reg - PTR_ONE;
        end
    end

    assign count = count_reg;
`endif

endmodule

// File: rtl/sm_job_receiver.sv
// Receiving end of the stage-dispatch link: steers each beat into the queue
// of its target SM; each SM pops its own queue through valid/ready.
// Optional macro SMJR_OCCUPANCY_EN exposes per-queue occupancy on sm_occ.
module sm_job_receiver
    import shader_dispatch_pkg::*;
#(
    parameter int NUM_SM   = 8,
    parameter int ID_WIDTH = 32,
    parameter int DEPTH    = 4,
    parameter int SM_IDX_W = (NUM_SM > 1) ? $clog2(NUM_SM) : 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SM_IDX_W-1:0]         in_sm,
    input  logic [STAGE_W-1:0]          in_stage,
    input  logic [ID_WIDTH-1:0]         in_job_id,
    output logic [NUM_SM-1:0]           sm_valid,
    input  logic [NUM_SM-1:0]           sm_ready,
    output logic [NUM_SM*STAGE_W-1:0]   sm_stage,
    output logic [NUM_SM*ID_WIDTH-1:0]  sm_job_id,
    output logic                        bad_sm_err
`ifdef SMJR_OCCUPANCY_EN
    ,
    output logic [NUM_SM*($clog2(DEPTH)+1)-1:0] sm_occ
`endif
);

    localparam int ENTRY_W = STAGE_W + ID_WIDTH;
    localparam int OCC_W   = $clog2(DEPTH) + 1;
    localparam int NUM_IDX = 1 << SM_IDX_W;

    // Full flags padded to every encodable index; nonexistent SMs never
    // look full, so beats aimed at them are taken and dropped.
    logic [NUM_IDX-1:0] full_pad;
    logic [NUM_SM-1:0]  push_vec;
    logic               in_range;
    logic               accept;
    logic               bad_sm_err_reg;

    assign in_range   = 32'(in_sm) < 32'(NUM_SM);
    assign in_ready   = !full_pad[in_sm];
    assign accept     = in_valid && in_ready;
    assign bad_sm_err = bad_sm_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IDX; gi++) begin : g_sm
            if (gi < NUM_SM) begin : g_queue
                logic [ENTRY_W-1:0] head;
                logic               empty;

                assign push_vec[gi] = accept && (in_sm == SM_IDX_W'(gi));

                sm_job_fifo #(
                    .WIDTH (ENTRY_W),
                    .DEPTH (DEPTH)
                ) u_fifo (
                    .clk       (clk),
                    .rstn      (rstn),
                    .push      (push_vec[gi]),
                    .push_data ({in_stage, in_job_id}),
                    .pop       (sm_ready[gi]),
                    .head_data (head),
                    .full      (full_pad[gi]),
                    .empty     (empty)
`ifdef SMJR_OCCUPANCY_EN
                    ,
                    .count     (sm_occ[gi*OCC_W +: OCC_W])
`endif
                );

                assign sm_valid[gi]                 = !empty;
                assign sm_stage[gi*STAGE_W +: STAGE_W] = head[ENTRY_W-1 -: STAGE_W];
                assign sm_job_id[gi*ID_WIDTH +: ID_WIDTH] = head[ID_WIDTH-1:0];
            end else begin : g_no_queue
                assign full_pad[gi] = 1'b0;
            end
        end
    endgenerate

    // Sticky flag for any accepted beat whose target SM does not exist.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bad_sm_err_reg <= 1'b0;
        end else if (accept && !in_range) begin
            bad_sm_err_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sm_job_receiver.sv
// Self-checking bench for sm_job_receiver using per-SM queue reference model.
// Built with NUM_SM=6 so that out-of-range indices 6 and 7 can be exercised.
module tb_sm_job_receiver;
    import shader_dispatch_pkg::*;

    localparam int NUM_SM   = 6;
    localparam int ID_WIDTH = 32;
    localparam int DEPTH    = 4;
    localparam int SM_IDX_W = 3;
    localparam int OCC_W    = $clog2(DEPTH) + 1;

    logic                        clk = 1'b0;
    logic                        rstn;
    logic                        in_valid;
    logic                        in_ready;
    logic [SM_IDX_W-1:0]         in_sm;
    logic [2:0]                  in_stage;
    logic [ID_WIDTH-1:0]         in_job_id;
    logic [NUM_SM-1:0]           sm_valid;
    logic [NUM_SM-1:0]           sm_ready;
    logic [NUM_SM*3-1:0]         sm_stage;
    logic [NUM_SM*ID_WIDTH-1:0]  sm_job_id;
    logic                        bad_sm_err;
`ifdef SMJR_OCCUPANCY_EN
    logic [NUM_SM*OCC_W-1:0]     sm_occ;
`endif

    always #5 clk = ~clk;

    sm_job_receiver #(
        .NUM_SM   (NUM_SM),
        .ID_WIDTH (ID_WIDTH),
        .DEPTH    (DEPTH),
        .SM_IDX_W (SM_IDX_W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sm      (in_sm),
        .in_stage   (in_stage),
        .in_job_id  (in_job_id),
        .sm_valid   (sm_valid),
        .sm_ready   (sm_ready),
        .sm_stage   (sm_stage),
        .sm_job_id  (sm_job_id),
        .bad_sm_err (bad_sm_err)
`ifdef SMJR_OCCUPANCY_EN
        ,
        .sm_occ     (sm_occ)
`endif
    );

    // Reference: one queue of {stage, job_id} per SM plus the sticky flag.
    logic [34:0] model_q [NUM_SM][$];
    bit          model_bad;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: inputs already driven after a negedge; check, update model, advance.
    task automatic step();
        logic [NUM_SM-1:0] exp_valid;
        bit                exp_ready;
        logic [34:0]       e;
        #1;
        if (int'(in_sm) >= NUM_SM) exp_ready = 1'b1;
        else                       exp_ready = (model_q[in_sm].size() < DEPTH);
        check_eq("in_ready", in_ready, exp_ready);
        for (int i = 0; i < NUM_SM; i++) exp_valid[i] = (model_q[i].size() > 0);
        check_eq("sm_valid", sm_valid, exp_valid);
        for (int i = 0; i < NUM_SM; i++) begin
            if (model_q[i].size() > 0) begin
                e = model_q[i][0];
                check_eq($sformatf("head_stage_sm%0d", i), sm_stage[3*i +: 3], e[34:32]);
                check_eq($sformatf("head_id_sm%0d", i), sm_job_id[ID_WIDTH*i +: ID_WIDTH], e[31:0]);
            end
`ifdef SMJR_OCCUPANCY_EN
            check_eq($sformatf("occ_sm%0d", i), sm_occ[OCC_W*i +: OCC_W], model_q[i].size());
`endif
        end
        check_eq("bad_sm_err", bad_sm_err, model_bad);

        if (!rstn) begin
            for (int i = 0; i < NUM_SM; i++) model_q[i].delete();
            model_bad = 1'b0;
            $display("t=%0t reset: all queues cleared", $time);
        end else begin
            for (int i = 0; i < NUM_SM; i++) begin
                if (sm_ready[i] && model_q[i].size() > 0) begin
                    e = model_q[i].pop_front();
                    $display("t=%0t pop  sm%0d stage=%0d id=0x%0h", $time, i, e[34:32], e[31:0]);
                end
            end
            if (in_valid && exp_ready) begin
                if (int'(in_sm) >= NUM_SM) begin
                    model_bad = 1'b1;
                    $display("t=%0t drop sm%0d id=0x%0h (bad index)", $time, in_sm, in_job_id);
                end else begin
                    model_q[in_sm].push_back({in_stage, in_job_id});
                    $display("t=%0t push sm%0d stage=%0d id=0x%0h", $time, in_sm, in_stage, in_job_id);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input int sm, input logic [2:0] st,
                         input logic [31:0] id, input logic [NUM_SM-1:0] rdy);
        in_valid  = v;
        in_sm     = SM_IDX_W'(sm);
        in_stage  = st;
        in_job_id = id;
        sm_ready  = rdy;
        step();
    endtask

    task automatic idle(input logic [NUM_SM-1:0] rdy);
        drive(1'b0, 0, 3'd0, 32'd0, rdy);
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_sm = '0; in_stage = '0; in_job_id = '0; sm_ready = '0;
        model_bad = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Reset state: everything empty, head outputs zero.
        check_eq("reset_stage", 64'(sm_stage), 64'd0);
        for (int i = 0; i < NUM_SM; i++)
            check_eq($sformatf("reset_id_sm%0d", i), sm_job_id[ID_WIDTH*i +: ID_WIDTH], 64'd0);
        idle('0);

        // Single push to SM3 appears one cycle later.
        drive(1'b1, 3, STAGE_COMPUTE, 32'h10, '0);
        check_eq("sm3_only_valid", sm_valid, 6'b001000);
        check_eq("sm3_stage", sm_stage[9 +: 3], STAGE_COMPUTE);
        check_eq("sm3_id", sm_job_id[96 +: 32], 32'h10);
        idle(6'b001000);

        // Fill SM0, check stall on SM0 while SM1 still accepts.
        drive(1'b1, 0, STAGE_VERTEX, 32'hA, '0);
        drive(1'b1, 0, STAGE_FRAG,   32'hB, '0);
        drive(1'b1, 0, STAGE_RAY,    32'hC, '0);
        drive(1'b1, 0, 3'd7,         32'hD, '0);
        drive(1'b1, 0, STAGE_VERTEX, 32'hE, '0);
        drive(1'b1, 1, 3'd5,         32'h11, '0);
        // Pop and push on a full queue together: push must wait a cycle.
        drive(1'b1, 0, STAGE_VERTEX, 32'hE, 6'b000001);
        drive(1'b1, 0, STAGE_VERTEX, 32'hE, '0);
        repeat (6) idle(6'b000011);

        // SM2 with two entries: simultaneous push+pop keeps occupancy.
        drive(1'b1, 2, STAGE_FRAG, 32'h21, '0);
        drive(1'b1, 2, STAGE_FRAG, 32'h22, '0);
        drive(1'b1, 2, STAGE_FRAG, 32'h23, 6'b000100);
        drive(1'b1, 2, STAGE_FRAG, 32'h24, 6'b000100);
        repeat (4) idle(6'b000100);

        // Bad index: accepted, dropped, sticky flag.
        drive(1'b1, 7, STAGE_RAY, 32'hBAD, '0);
        check_eq("bad_flag_set", bad_sm_err, 1'b1);
        drive(1'b1, 6, STAGE_RAY, 32'hBAD2, '0);
        idle('0);

        // Mid-operation reset discards queued jobs and clears the flag.
        drive(1'b1, 1, STAGE_COMPUTE, 32'h31, '0);
        drive(1'b1, 1, STAGE_COMPUTE, 32'h32, '0);
        drive(1'b1, 1, STAGE_COMPUTE, 32'h33, '0);
        rstn = 1'b0;
        idle('0);
        rstn = 1'b1;
        check_eq("post_reset_valid", sm_valid, 6'd0);
        check_eq("post_reset_bad", bad_sm_err, 1'b0);
        drive(1'b1, 1, STAGE_FRAG, 32'h40, '0);
        check_eq("new_head_id", sm_job_id[32 +: 32], 32'h40);
        idle(6'b000010);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            logic [NUM_SM-1:0] rdy;
            for (int i = 0; i < NUM_SM; i++) rdy[i] = ($urandom_range(0, 9) < 3);
            rstn = ($urandom_range(0, 299) != 0);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 7), 3'($urandom_range(0, 7)),
                  $urandom, rdy);
        end
        rstn = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
